// File: rtl/bram_heap_ctrl.sv
// bram_heap_ctrl: binary min-heap held in a two-port synchronous-read memory.
// Push sifts the new key up from the tail, pop moves the tail to the root and
// sifts it down, and push+pop together replaces the root and sifts down.
// The travelling key stays in cur and is written only into its final slot.
// Each level takes two cycles: one to issue the reads and one to compare.
module bram_heap_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 15
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_push,
    input  logic [DATA_WIDTH-1:0]        i_push_data,
    input  logic                         i_pop,
    output logic                         o_ready,
    output logic [DATA_WIDTH-1:0]        o_top,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_empty,
    output logic                         o_full,
    output logic                         o_err
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, POP_LOAD, SD_READ, SD_CMP, SU_READ, SU_CMP} state_t;

    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] cur, cur_n;
    logic [CW-1:0]         idx, idx_n;
    logic [CW-1:0]         count, count_n;
    logic [DATA_WIDTH-1:0] top;
    logic                  err, err_n;

    // memory ports: port A reads and writes, port B is a second read port
    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic                  we;
    logic [AW-1:0]         waddr, raddr_a, raddr_b;
    logic [DATA_WIDTH-1:0] wdata, rdata_a, rdata_b;

    // child/parent index arithmetic, one bit wider so 2*idx+2 never wraps
    logic [CW:0]           lc, rc, cnt_w;
    logic [CW-1:0]         idx_m1, pidx, cnt_m1;
    logic [DATA_WIDTH-1:0] rval;
    logic                  take_left;

    assign cnt_w     = {1'b0, count};
    assign lc        = {idx, 1'b1};
    assign rc        = lc + (CW+1)'(1);
    assign idx_m1    = idx - CW'(1);
    assign pidx      = idx_m1 >> 1;
    assign cnt_m1    = count - CW'(1);
    // a missing right child must never win the comparison
    assign rval      = (rc >= cnt_w) ? {DATA_WIDTH{1'b1}} : rdata_b;
    // ties go to the right child
    assign take_left = rdata_a < rval;

    assign o_ready = (state == IDLE);
    assign o_top   = top;
    assign o_count = count;
    assign o_empty = (count == '0);
    assign o_full  = (count == CW'(DEPTH));
    assign o_err   = err;

    // state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_n;
    end

    // next-state, datapath next values and memory port control
    always_comb begin
        state_n = state;
        cur_n   = cur;
        idx_n   = idx;
        count_n = count;
        err_n   = 1'b0;
        we      = 1'b0;
        waddr   = idx[AW-1:0];
        wdata   = cur;
        raddr_a = '0;
        raddr_b = '0;
        case (state)
            IDLE: begin
                if (i_push && i_pop && !o_empty) begin
                    cur_n   = i_push_data;
                    idx_n   = '0;
                    state_n = SD_READ;
                end else if (i_push) begin
                    if (o_full) begin
                        err_n = 1'b1;
                    end else begin
                        cur_n   = i_push_data;
                        idx_n   = count;
                        count_n = count + CW'(1);
                        state_n = SU_READ;
                    end
                end else if (i_pop) begin
                    if (o_empty) begin
                        err_n = 1'b1;
                    end else begin
                        raddr_a = cnt_m1[AW-1:0];
                        count_n = cnt_m1;
                        state_n = POP_LOAD;
                    end
                end
            end
            POP_LOAD: begin
                cur_n   = rdata_a;
                idx_n   = '0;
                state_n = (count == '0) ? IDLE : SD_READ;
            end
            SD_READ: begin
                if (lc >= cnt_w) begin
                    we      = 1'b1;
                    state_n = IDLE;
                end else begin
                    raddr_a = lc[AW-1:0];
                    raddr_b = rc[AW-1:0];
                    state_n = SD_CMP;
                end
            end
            SD_CMP: begin
                if (take_left && cur > rdata_a) begin
                    we      = 1'b1;
                    wdata   = rdata_a;
                    idx_n   = lc[CW-1:0];
                    state_n = SD_READ;
                end else if (!take_left && cur > rval) begin
                    we      = 1'b1;
                    wdata   = rval;
                    idx_n   = rc[CW-1:0];
                    state_n = SD_READ;
                end else begin
                    we      = 1'b1;
                    state_n = IDLE;
                end
            end
            SU_READ: begin
                if (idx == '0) begin
                    we      = 1'b1;
                    state_n = IDLE;
                end else begin
                    raddr_a = pidx[AW-1:0];
                    state_n = SU_CMP;
                end
            end
            SU_CMP: begin
                we = 1'b1;
                if (rdata_a > cur) begin
                    wdata   = rdata_a;
                    idx_n   = pidx;
                    state_n = SU_READ;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // datapath registers; o_top mirrors every write to the root
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cur   <= '0;
            idx   <= '0;
            count <= '0;
            top   <= '0;
            err   <= 1'b0;
        end else begin
            cur   <= cur_n;
            idx   <= idx_n;
            count <= count_n;
            err   <= err_n;
            if (we && waddr == '0) top <= wdata;
        end
    end

    // heap storage, not reset; reads have one cycle of latency
    always_ff @(posedge i_clk) begin
        if (we) mem[waddr] <= wdata;
        rdata_a <= mem[raddr_a];
        rdata_b <= mem[raddr_b];
    end
endmodule

// File: tb/tb_bram_heap_ctrl.sv
// Directed bench for bram_heap_ctrl with hand-computed heap contents.
module tb_bram_heap_ctrl;
    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b1;
    logic        i_push = 1'b0;
    logic [31:0] i_push_data = '0;
    logic        i_pop = 1'b0;
    logic        o_ready;
    logic [31:0] o_top;
    logic [3:0]  o_count;
    logic        o_empty;
    logic        o_full;
    logic        o_err;

    int errors = 0;
    int checks = 0;
    int err_seen = 0;
    int err_base;
    int cyc;

    logic [31:0] fill_in  [15] = '{50, 20, 70, 10, 90, 30, 60, 40, 80, 5, 15, 25, 35, 45, 55};
    logic [31:0] fill_out [15] = '{5, 10, 15, 20, 25, 30, 35, 40, 45, 50, 55, 60, 70, 80, 90};
    logic [31:0] push_top [4]  = '{5, 3, 3, 1};

    bram_heap_ctrl #(.DATA_WIDTH(32), .DEPTH(15)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_push(i_push), .i_push_data(i_push_data),
        .i_pop(i_pop), .o_ready(o_ready), .o_top(o_top), .o_count(o_count),
        .o_empty(o_empty), .o_full(o_full), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    // count o_err pulses, one per high cycle
    always @(negedge i_clk) if (o_err) err_seen++;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // issue one request when ready, return cycles until ready again
    task automatic req(input logic push, input logic pop, input logic [31:0] d, output int c);
        int w;
        w = 0;
        while (!o_ready && w < 200) begin @(negedge i_clk); w++; end
        if (!o_ready) chk("ready_timeout", 32'(o_ready), 1);
        i_push = push; i_pop = pop; i_push_data = d;
        @(negedge i_clk);
        i_push = 1'b0; i_pop = 1'b0;
        c = 0;
        while (!o_ready && c < 200) begin @(negedge i_clk); c++; end
        if (!o_ready) chk("done_timeout", 32'(o_ready), 1);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 i_rst_n = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        chk("rst_ready", 32'(o_ready), 1);
        chk("rst_empty", 32'(o_empty), 1);
        chk("rst_count", 32'(o_count), 0);
        chk("rst_top", o_top, 0);
        chk("rst_err", 32'(o_err), 0);

        // pushes 5,3,8,1 -> heap {1,3,8,5}
        for (int i = 0; i < 4; i++) begin
            req(1'b1, 1'b0, (i == 0) ? 32'd5 : (i == 1) ? 32'd3 : (i == 2) ? 32'd8 : 32'd1, cyc);
            chk("push_top", o_top, push_top[i]);
        end
        chk("push_count", 32'(o_count), 4);

        // four pops: root follows 3,5,8 then stays stale at 8
        err_base = err_seen;
        req(1'b0, 1'b1, 0, cyc); chk("pop1_top", o_top, 3);
        req(1'b0, 1'b1, 0, cyc); chk("pop2_top", o_top, 5);
        req(1'b0, 1'b1, 0, cyc); chk("pop3_top", o_top, 8);
        req(1'b0, 1'b1, 0, cyc); chk("pop4_stale", o_top, 8);
        chk("pop_empty", 32'(o_empty), 1);
        chk("pop_noerr", 32'(err_seen - err_base), 0);

        // push+pop on empty heap acts as a plain push
        req(1'b1, 1'b1, 11, cyc);
        chk("pp_empty_count", 32'(o_count), 1);
        chk("pp_empty_top", o_top, 11);
        chk("pp_empty_noerr", 32'(err_seen - err_base), 0);
        req(1'b0, 1'b1, 0, cyc);

        // replace on {2,4,6}: result {4,9,6}
        req(1'b1, 1'b0, 2, cyc);
        req(1'b1, 1'b0, 4, cyc);
        req(1'b1, 1'b0, 6, cyc);
        req(1'b1, 1'b1, 9, cyc);
        chk("repl_count", 32'(o_count), 3);
        chk("repl_top", o_top, 4);
        req(1'b0, 1'b1, 0, cyc); chk("repl_pop1", o_top, 6);
        req(1'b0, 1'b1, 0, cyc); chk("repl_pop2", o_top, 9);
        req(1'b0, 1'b1, 0, cyc); chk("repl_drain", 32'(o_empty), 1);

        // fill to capacity, overflow push, drain in order, underflow pop
        for (int i = 0; i < 15; i++) req(1'b1, 1'b0, fill_in[i], cyc);
        chk("fill_full", 32'(o_full), 1);
        chk("fill_top", o_top, 5);
        err_base = err_seen;
        req(1'b1, 1'b0, 1, cyc);
        chk("ovf_err", 32'(err_seen - err_base), 1);
        chk("ovf_count", 32'(o_count), 15);
        chk("ovf_top", o_top, 5);
        for (int i = 0; i < 15; i++) begin
            chk("drain_top", o_top, fill_out[i]);
            req(1'b0, 1'b1, 0, cyc);
        end
        chk("drain_empty", 32'(o_empty), 1);
        err_base = err_seen;
        req(1'b0, 1'b1, 0, cyc);
        chk("unf_err", 32'(err_seen - err_base), 1);
        chk("unf_count", 32'(o_count), 0);

        // duplicates: no swap, first pop finishes after one compare level
        for (int i = 0; i < 3; i++) req(1'b1, 1'b0, 7, cyc);
        chk("dup_top", o_top, 7);
        req(1'b0, 1'b1, 0, cyc);
        chk("dup_pop1_top", o_top, 7);
        chk("dup_pop1_cycles", 32'(cyc), 3);
        req(1'b0, 1'b1, 0, cyc); chk("dup_pop2_top", o_top, 7);
        req(1'b0, 1'b1, 0, cyc); chk("dup_pop3_empty", 32'(o_empty), 1);

        // reset asserted while the pop sits in SD_CMP
        req(1'b1, 1'b0, 1, cyc);
        req(1'b1, 1'b0, 2, cyc);
        req(1'b1, 1'b0, 3, cyc);
        i_pop = 1'b1;
        @(negedge i_clk);   // POP_LOAD
        i_pop = 1'b0;
        @(negedge i_clk);   // SD_READ
        @(negedge i_clk);   // SD_CMP
        chk("mid_busy", 32'(o_ready), 0);
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(o_ready), 1);
        chk("mid_rst_count", 32'(o_count), 0);
        chk("mid_rst_empty", 32'(o_empty), 1);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        req(1'b1, 1'b0, 4, cyc);
        chk("post_rst_top", o_top, 4);
        chk("post_rst_count", 32'(o_count), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
